// File: rtl/vc_pkg.sv
// rtl/vc_pkg.sv - shared types, defaults and helpers for the voice-corruptor sequencer
package vc_pkg;

  // Default echo RAM address width; buffer depth is 2**ADDR_W samples.
  localparam int ADDR_W_DEF = 13;

  // Sequence phases, in the order the FSM walks them.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_WR   = 3'd5,
    ST_T4   = 3'd6
  } state_t;

  // A zero delay would read the slot about to be overwritten; treat it as one sample.
  function automatic logic [31:0] sat_delay(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/vc_if.sv
// rtl/vc_if.sv - control/RAM/strobe bundle between sample source, sequencer and datapath
interface vc_if
  import vc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              enable;
  logic              data_valid;
  logic [ADDR_W-1:0] delay;
  logic              clr_ovr;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              t1;
  logic              t2;
  logic              t3;
  logic              t4;
  logic              busy;
  logic              done;
  logic              overrun;

  // Side that supplies ticks and configuration and consumes strobes.
  modport master (
    output enable, data_valid, delay, clr_ovr,
    input  ram_addr, ram_we, t1, t2, t3, t4, busy, done, overrun
  );

  // The sequencer itself.
  modport slave (
    input  enable, data_valid, delay, clr_ovr,
    output ram_addr, ram_we, t1, t2, t3, t4, busy, done, overrun
  );

endinterface

// File: rtl/vc_ring_ptr.sv
// rtl/vc_ring_ptr.sv - circular echo-buffer write pointer and delayed read address
module vc_ring_ptr
  import vc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic [ADDR_W-1:0] delay,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_addr
);

  logic [ADDR_W-1:0] d_sat;

  assign d_sat   = ADDR_W'(sat_delay(32'(delay)));
  // Modular subtract: the buffer is a power of two, so wrap-around is free.
  assign rd_addr = wr_ptr - d_sat;

  // Write pointer advances once per completed write, wrapping at the buffer end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (inc) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/vc_sequencer.sv
// rtl/vc_sequencer.sv - per-sample echo read / gain phase / write-back sequencer
module vc_sequencer
  import vc_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int RAM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  vc_if.slave  bus
);

  localparam logic [2:0] LAT_LAST = 3'(RAM_LAT - 1);

  state_t            state;
  state_t            state_nx;
  logic [2:0]        lat_cnt;
  logic              start;
  logic              ovr_set;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_addr;

  assign start   = (state == ST_IDLE) && bus.data_valid && bus.enable;
  assign ovr_set = (state != ST_IDLE) && bus.data_valid;

  vc_ring_ptr #(.ADDR_W(ADDR_W)) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (state == ST_WR),
    .delay   (bus.delay),
    .wr_ptr  (wr_ptr),
    .rd_addr (rd_addr)
  );

  // State register plus the RAM latency down-counter used while in RD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      lat_cnt <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        lat_cnt <= LAT_LAST;
      end else if (state == ST_RD && lat_cnt != 3'd0) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
    end
  end

  // Next-state: fixed walk through the phases once started.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RD;
      ST_RD:   if (lat_cnt == 3'd0) state_nx = ST_T1;
      ST_T1:   state_nx = ST_T2;
      ST_T2:   state_nx = ST_T3;
      ST_T3:   state_nx = ST_WR;
      ST_WR:   state_nx = ST_T4;
      ST_T4:   state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Strobes decoded from the registered state only, so they are glitch-free.
  always_comb begin
    bus.t1     = 1'b0;
    bus.t2     = 1'b0;
    bus.t3     = 1'b0;
    bus.t4     = 1'b0;
    bus.ram_we = 1'b0;
    bus.done   = 1'b0;
    bus.busy   = (state != ST_IDLE);
    case (state)
      ST_T1:   bus.t1 = 1'b1;
      ST_T2:   bus.t2 = 1'b1;
      ST_T3:   bus.t3 = 1'b1;
      ST_WR:   bus.ram_we = 1'b1;
      ST_T4: begin
        bus.t4   = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  // RAM address: delayed read slot from the start tick, write slot ahead of WR, else held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ram_addr <= '0;
    end else if (start) begin
      bus.ram_addr <= rd_addr;
    end else if (state == ST_T3) begin
      bus.ram_addr <= wr_ptr;
    end
  end

  // Sticky overrun: a tick while busy is dropped and flagged; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.overrun <= 1'b0;
    end else if (ovr_set) begin
      bus.overrun <= 1'b1;
    end else if (bus.clr_ovr) begin
      bus.overrun <= 1'b0;
    end
  end

endmodule
